hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RISC-V core. It sits beside the main ControlUnit and produces the enable and flush strobes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Decoded control bits (MemRead, MemWrite, RegWrite, Branch) arrive from the stage registers. The block resolves load-use hazards, taken-branch flushes and data-memory wait states, and runs a memory-timeout watchdog plus saturating performance counters.

## Interface
- MEM_TIMEOUT, 64: max consecutive dmem wait cycles before HALT (≥2)
- CNT_W, 32: performance counter width

- clk  in  1  core clock
- rst_n  in  1  synchronous reset, active low
- id_rs1, id_rs2  in  5 each  source registers of instruction in ID
- id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2
- ex_rd  in  5  destination of instruction in EX
- ex_MemRead  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX branch resolved taken (Branch & condition)
- mem_MemRead, mem_MemWrite  in  1 each  MEM instruction accesses dmem
- dmem_ready  in  1  dmem completes access this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register load enables
- ifid_flush, idex_flush, memwb_flush  out  1 each  load a bubble (all control bits 0)
- halted  out  1  sticky watchdog error
- stall_cnt, flush_cnt  out  CNT_W each  perf counters

## Operation
- FSM states: RUN, MEM_WAIT, HALT.
- Priority, highest first: HALT > memory wait > taken branch > load-use.
- Memory wait condition: (mem_MemRead|mem_MemWrite) & ~dmem_ready.
  - In RUN or MEM_WAIT it clears pc_en, ifid_en, idex_en and exmem_en.
  - memwb_en=1 with memwb_flush=1, so a bubble enters WB.
  - RUN→MEM_WAIT on first wait cycle. wait_cnt is cleared on entry and increments each further wait cycle.
  - MEM_WAIT→RUN the cycle dmem_ready=1; that cycle is a normal RUN cycle (all enables 1).
  - If wait_cnt reaches MEM_TIMEOUT-1 while still waiting → HALT.
- Taken branch, not stalled on memory: all enables 1, ifid_flush=1, idex_flush=1.
  - The redirect PC is loaded by the PC mux outside this block.
  - A branch held in EX during a memory stall is not lost, because EX/MEM is frozen. The flush fires on the first unstalled cycle.
- Load-use hazard: ex_MemRead & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - pc_en=0, ifid_en=0, idex_flush=1, others enabled.
  - Applies only with no memory wait and no taken branch. A taken branch squashes the dependent instruction anyway.
- Register x0 never causes a hazard.
- HALT: all enables 0, all flushes 0, halted=1. Only reset exits HALT.
- Counters, both saturating at all-ones:
  - stall_cnt +1 on every cycle with pc_en=0 outside HALT.
  - flush_cnt +1 on every taken-branch flush cycle.

## Timing
- Enables and flushes are combinational (Mealy) from current state and same-cycle inputs, and are sampled by the stage registers at the next clk edge.
- State, wait_cnt, halted and counters update on posedge clk.
- Reset (rst_n=0 at posedge):
  - State and registers: state=RUN, wait_cnt=0, halted=0, stall_cnt=0, flush_cnt=0.
  - While rst_n=0, outputs are forced: all enables 0, ifid_flush=idex_flush=memwb_flush=1.
  - Reset mid-MEM_WAIT or in HALT returns to RUN with no residual stall.
- Load-use stall is exactly 1 cycle; the hazard clears once the load advances to MEM.
- Branch flush costs exactly 2 bubbles.
- Timeout: with dmem_ready held 0, HALT is entered at the edge ending the MEM_TIMEOUT-th wait cycle. halted is high on the following cycle.
- Simultaneous memory wait, taken branch and load-use: only the memory-wait response applies. The branch and load-use are re-evaluated after release.

## Structure
- Shared package core_pkg:
  - state enum hz_state_t {RUN, MEM_WAIT, HALT}
  - REG_X0 = 5'd0
- One sub-module: sat_counter (parameter W; inputs clk, rst_n, inc; output count), instantiated twice for stall_cnt and flush_cnt.
- hazard_ctrl itself contains the FSM, wait_cnt and the combinational strobe logic.

## Test plan
- Load-use: ex_MemRead=1, ex_rd=5, id_rs1=5, id_use_rs1=1, dmem_ready=1 → one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt 0→1.
- x0 and unused source:
  - ex_rd=0, id_rs1=0 → no stall.
  - ex_rd=7, id_rs2=7, id_use_rs2=0 → no stall.
- Branch: ex_branch_taken=1 for one cycle → ifid_flush=idex_flush=1, all enables 1; flush_cnt=1.
- Memory wait: mem_MemRead=1, dmem_ready=0 for 3 cycles, then 1.
  - Each wait cycle: pc/ifid/idex/exmem enables 0, memwb_flush=1.
  - Returns to RUN on the ready cycle; stall_cnt=3.
  - ex_branch_taken held 1 throughout → flush only on the ready cycle.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 → halted=1 after the 4th wait cycle; all enables stay 0. rst_n=0 for one edge → halted=0, state RUN, counters 0.
- Saturation: CNT_W=3, 10 consecutive load-use stalls → stall_cnt holds at 7.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the pipeline control blocks of the 5-stage core.
package core_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage : core_pkg

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + ONE;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_counter

// File: rtl/hazard_ctrl.sv
// Stall/flush controller: load-use, taken-branch and dmem wait handling,
// a dmem timeout watchdog and saturating stall/flush counters.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_MemRead,
    input  logic             ex_branch_taken,
    input  logic             mem_MemRead,
    input  logic             mem_MemWrite,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    // wait_cnt lags the wait-cycle count by one, so this is the last MEM_WAIT
    // cycle before the MEM_TIMEOUT-th consecutive wait cycle ends.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 2);

    hz_state_t         state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic mem_wait, load_use;
    logic stall_inc, flush_inc;
    logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
    logic ifid_flush_c, idex_flush_c, memwb_flush_c;

    assign mem_wait = (mem_MemRead | mem_MemWrite) & ~dmem_ready;
    assign load_use = ex_MemRead && (ex_rd != REG_X0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    // NOTE: every always_comb output gets a default first, so no latches form.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        pc_en_c       = 1'b1;
        ifid_en_c     = 1'b1;
        idex_en_c     = 1'b1;
        exmem_en_c    = 1'b1;
        memwb_en_c    = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        memwb_flush_c = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;

        if (state_q == HALT) begin
            pc_en_c    = 1'b0;
            ifid_en_c  = 1'b0;
            idex_en_c  = 1'b0;
            exmem_en_c = 1'b0;
            memwb_en_c = 1'b0;
        end else if (mem_wait) begin
            // Freeze everything up to EX/MEM; WB takes a bubble.
            pc_en_c       = 1'b0;
            ifid_en_c     = 1'b0;
            idex_en_c     = 1'b0;
            exmem_en_c    = 1'b0;
            memwb_flush_c = 1'b1;
            stall_inc     = 1'b1;
            if (state_q != MEM_WAIT) begin
                state_d    = MEM_WAIT;
                wait_cnt_d = '0;
            end else if (wait_cnt_q == WAIT_LAST) begin
                state_d = HALT;
            end else begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
        end else begin
            state_d = RUN;
            if (ex_branch_taken) begin
                ifid_flush_c = 1'b1;
                idex_flush_c = 1'b1;
                flush_inc    = 1'b1;
            end else if (load_use) begin
                pc_en_c      = 1'b0;
                ifid_en_c    = 1'b0;
                idex_flush_c = 1'b1;
                stall_inc    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Reset holds every stage frozen and loads bubbles.
    assign pc_en       = rst_n & pc_en_c;
    assign ifid_en     = rst_n & ifid_en_c;
    assign idex_en     = rst_n & idex_en_c;
    assign exmem_en    = rst_n & exmem_en_c;
    assign memwb_en    = rst_n & memwb_en_c;
    assign ifid_flush  = ~rst_n | ifid_flush_c;
    assign idex_flush  = ~rst_n | idex_flush_c;
    assign memwb_flush = ~rst_n | memwb_flush_c;
    assign halted      = (state_q == HALT);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random
// stimulus compared every cycle against a rule-level reference model.
module tb_hazard_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 3;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_use_rs1, id_use_rs2;
    logic             ex_MemRead, ex_branch_taken;
    logic             mem_MemRead, mem_MemWrite, dmem_ready;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush, memwb_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: halted flag, run of consecutive wait cycles, counts.
    bit m_halted   = 1'b0;
    int m_wait_run = 0;
    int m_stall    = 0;
    int m_flush    = 0;

    hazard_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_rd           (ex_rd),
        .ex_MemRead      (ex_MemRead),
        .ex_branch_taken (ex_branch_taken),
        .mem_MemRead     (mem_MemRead),
        .mem_MemWrite    (mem_MemWrite),
        .dmem_ready      (dmem_ready),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .memwb_flush     (memwb_flush),
        .halted          (halted),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        rst_n           = 1'b1;
        id_rs1          = 5'd0;
        id_rs2          = 5'd0;
        id_use_rs1      = 1'b0;
        id_use_rs2      = 1'b0;
        ex_rd           = 5'd0;
        ex_MemRead      = 1'b0;
        ex_branch_taken = 1'b0;
        mem_MemRead     = 1'b0;
        mem_MemWrite    = 1'b0;
        dmem_ready      = 1'b1;
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    // One clock: inputs are already set (at negedge); check outputs against
    // the model, take the edge, advance the model, return at the next negedge.
    task automatic cycle();
        bit       w, lu, br;
        bit [7:0] exp_s;
        #1;
        w  = (mem_MemRead || mem_MemWrite) && !dmem_ready;
        br = ex_branch_taken;
        lu = ex_MemRead && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        // {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, memwb_fl}
        if (!rst_n)        exp_s = 8'b00000_111;
        else if (m_halted) exp_s = 8'b00000_000;
        else if (w)        exp_s = 8'b00001_001;
        else if (br)       exp_s = 8'b11111_110;
        else if (lu)       exp_s = 8'b00111_010;
        else               exp_s = 8'b11111_000;
        check("strobes", {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                          ifid_flush, idex_flush, memwb_flush}, exp_s);
        check("halted", halted, m_halted);
        check("stall_cnt", stall_cnt, m_stall);
        check("flush_cnt", flush_cnt, m_flush);
        @(posedge clk);
        if (!rst_n) begin
            m_halted   = 1'b0;
            m_wait_run = 0;
            m_stall    = 0;
            m_flush    = 0;
        end else if (!m_halted) begin
            if (w) begin
                m_wait_run++;
                m_stall = sat_inc(m_stall);
                if (m_wait_run == MEM_TIMEOUT) m_halted = 1'b1;
            end else begin
                m_wait_run = 0;
                if (br)      m_flush = sat_inc(m_flush);
                else if (lu) m_stall = sat_inc(m_stall);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        idle();
        rst_n = 1'b0;
        repeat (n) cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        @(negedge clk);
        do_reset(2);

        // Load-use on rs1: one stall cycle, then the load moves on.
        ex_MemRead = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        cycle();
        idle();
        cycle();
        check("lu_stall_cnt", stall_cnt, 1);

        // x0 destination, and a matching but unused rs2: no stall.
        ex_MemRead = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        cycle();
        idle();
        ex_MemRead = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b0;
        cycle();
        check("no_hazard_stall_cnt", stall_cnt, 1);

        // Single taken branch.
        idle();
        ex_branch_taken = 1'b1;
        cycle();
        idle();
        cycle();
        check("branch_flush_cnt", flush_cnt, 1);

        // Three wait cycles with a branch held in EX; flush only on release.
        idle();
        mem_MemRead = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
        repeat (3) cycle();
        check("memwait_no_flush", flush_cnt, 1);
        dmem_ready = 1'b1;
        cycle();
        idle();
        cycle();
        check("memwait_stall_cnt", stall_cnt, 4);
        check("memwait_flush_cnt", flush_cnt, 2);

        // Watchdog: dmem never ready.
        do_reset(1);
        mem_MemRead = 1'b1; dmem_ready = 1'b0;
        repeat (MEM_TIMEOUT) cycle();
        check("timeout_halted", halted, 1'b1);
        dmem_ready = 1'b1; ex_branch_taken = 1'b1;
        repeat (2) cycle();
        check("halt_sticky", halted, 1'b1);
        check("halt_pc_en", pc_en, 1'b0);
        do_reset(1);
        idle();
        check("reset_halted", halted, 1'b0);
        check("reset_stall_cnt", stall_cnt, 0);
        check("reset_flush_cnt", flush_cnt, 0);
        cycle();
        check("after_reset_run", pc_en, 1'b1);

        // Saturation of the stall counter.
        ex_MemRead = 1'b1; ex_rd = 5'd3; id_rs2 = 5'd3; id_use_rs2 = 1'b1;
        repeat (10) cycle();
        check("stall_saturated", stall_cnt, CNT_MAX);

        // Random traffic with small register numbers to provoke hazards.
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            rst_n           = ($urandom_range(0, 49) != 0);
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            id_use_rs1      = 1'($urandom_range(0, 1));
            id_use_rs2      = 1'($urandom_range(0, 1));
            ex_MemRead      = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 3) == 0);
            mem_MemRead     = ($urandom_range(0, 3) == 0);
            mem_MemWrite    = ($urandom_range(0, 5) == 0);
            dmem_ready      = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_hazard_ctrl
